// File: rtl/tt_arb_pkg.sv
// tt_arb_pkg: shared state encoding, bus width and slice helper for the uio bus arbiter
package tt_arb_pkg;

    typedef enum logic [1:0] {IDLE, TURN, GRANT} state_e;

    localparam int BUS_W = 8;

    function automatic logic [BUS_W-1:0] bus_slice(input logic [8*BUS_W-1:0] v, input int i);
        return v[i*BUS_W +: BUS_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (wrapping)
module rr_pick #(
    parameter int NREQ = 4,
    parameter int OW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [OW-1:0]   ptr_i,
    output logic            valid_o,
    output logic [OW-1:0]   owner_o
);

    logic [OW-1:0] idx;

    assign valid_o = |req_i;

    // scan from farthest to nearest so the closest request to ptr wins
    always_comb begin
        owner_o = '0;
        idx     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = OW'((int'(ptr_i) + i) % NREQ);
            if (req_i[idx]) owner_o = idx;
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the uio pad bus with turnaround and hold timeout (optional stats: ARB_STATS_EN)
module uio_bus_arbiter
    import tt_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int TURN_CYC = 2,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     rel,
    input  logic [NREQ*8-1:0]   req_out,
    input  logic [NREQ*8-1:0]   req_oe,
    output logic [NREQ-1:0]     gnt,
    output logic [BUS_W-1:0]    uio_out,
    output logic [BUS_W-1:0]    uio_oe,
    output logic                busy,
    output logic                timeout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]         grant_cnt,
    output logic [7:0]          timeout_cnt
`endif
);

    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TURN_CYC + 1);

    state_e            state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d, owner_q, owner_d, pick, ptr_nxt;
    logic [TW-1:0]     turn_q, turn_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NREQ-1:0]   gnt_d;
    logic [BUS_W-1:0]  out_d, oe_d;
    logic              timeout_d, pick_v, req_own, rel_own, to_hit;

    rr_pick #(.NREQ(NREQ), .OW(OW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_v),
        .owner_o (pick)
    );

    assign req_own = req[owner_q];
    assign rel_own = rel[owner_q];
    assign to_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));
    assign ptr_nxt = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign busy    = state_q != IDLE;

    // next state, counters and the values the output registers load; outputs default to a released bus
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        turn_d    = turn_q;
        hold_d    = hold_q;
        gnt_d     = '0;
        out_d     = '0;
        oe_d      = '0;
        timeout_d = 1'b0;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_v) begin
                        state_d = TURN;
                        owner_d = pick;
                        turn_d  = '0;
                    end
                end
                TURN: begin
                    if (!req_own) begin
                        state_d = IDLE;
                    end else if (turn_q == TW'(TURN_CYC - 1)) begin
                        state_d        = GRANT;
                        gnt_d[owner_q] = 1'b1;
                        hold_d         = HOLD_W'(1);
                    end else begin
                        turn_d = turn_q + 1'b1;
                    end
                end
                GRANT: begin
                    if (rel_own || !req_own || to_hit) begin
                        state_d   = IDLE;
                        ptr_d     = ptr_nxt;
                        timeout_d = to_hit && !rel_own && req_own;
                    end else begin
                        gnt_d[owner_q] = 1'b1;
                        hold_d         = hold_q + 1'b1;
                        out_d          = bus_slice(64'(req_out), int'(owner_q));
                        oe_d           = bus_slice(64'(req_oe), int'(owner_q));
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, pointer, counters and registered pad outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            turn_q  <= '0;
            hold_q  <= '0;
            gnt     <= '0;
            uio_out <= '0;
            uio_oe  <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            turn_q  <= turn_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            uio_out <= out_d;
            uio_oe  <= oe_d;
            timeout <= timeout_d;
        end
    end

`ifdef ARB_STATS_EN
    // saturating grant and timeout counters
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state_q == TURN && state_d == GRANT && grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 1'b1;
            if (timeout_d && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: directed self-checking bench for uio_bus_arbiter (NREQ=4, TURN_CYC=2, MAX_HOLD=8)
module tb_uio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, ena;
    logic [3:0]  req, rel, gnt;
    logic [31:0] req_out, req_oe;
    logic [7:0]  uio_out, uio_oe;
    logic        busy, timeout;
`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [7:0]  timeout_cnt;
`endif

    logic [7:0] oe_tab [4] = '{8'hF0, 8'h0F, 8'hC3, 8'h3C};
    logic [7:0] out_tab[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    int checks = 0;
    int errors = 0;

    uio_bus_arbiter #(.NREQ(4), .TURN_CYC(2), .MAX_HOLD(8), .HOLD_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .rel     (rel),
        .req_out (req_out),
        .req_oe  (req_oe),
        .gnt     (gnt),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .busy    (busy),
        .timeout (timeout)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt),
        .timeout_cnt (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp;
        ena = 1'b1;
        req = '0;
        rel = '0;
        for (int i = 0; i < 4; i++) begin
            req_oe[i*8 +: 8]  = oe_tab[i];
            req_out[i*8 +: 8] = out_tab[i];
        end
        do_reset();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_oe", 32'(uio_oe), 0);
        check("rst_out", 32'(uio_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout), 0);

        // single owner: grant after edge 3, drive after edge 4, rel releases
        req = 4'b0001;
        tick();
        check("t1_busy_e1", 32'(busy), 1);
        check("t1_gnt_e1", 32'(gnt), 0);
        tick();
        check("t1_gnt_e2", 32'(gnt), 0);
        tick();
        check("t1_gnt_e3", 32'(gnt), 4'b0001);
        check("t1_oe_e3", 32'(uio_oe), 0);
        tick();
        check("t1_oe_e4", 32'(uio_oe), 8'hF0);
        check("t1_out_e4", 32'(uio_out), 8'hA0);
        rel = 4'b0001;
        tick();
        rel = '0;
        req = '0;
        check("t1_gnt_rel", 32'(gnt), 0);
        check("t1_oe_rel", 32'(uio_oe), 0);
        check("t1_busy_rel", 32'(busy), 0);
        check("t1_timeout_rel", 32'(timeout), 0);

        // round robin with all requesters: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            tick();
            check("t2_busy_turn", 32'(busy), 1);
            check("t2_gnt_turn", 32'(gnt), 0);
            tick();
            check("t2_oe_turn", 32'(uio_oe), 0);
            tick();
            check("t2_gnt", 32'(gnt), 32'(exp));
            check("t2_oe_gnt1", 32'(uio_oe), 0);
            tick();
            check("t2_oe_drive", 32'(uio_oe), 32'(oe_tab[k % 4]));
            check("t2_out_drive", 32'(uio_out), 32'(out_tab[k % 4]));
            tick();
            rel = exp;
            tick();
            rel = '0;
            check("t2_gnt_rel", 32'(gnt), 0);
            check("t2_oe_rel", 32'(uio_oe), 0);
        end
`ifdef ARB_STATS_EN
        check("t2_grant_cnt", 32'(grant_cnt), 5);
`endif

        // timeout on owner 1 after 8 grant cycles, then requester 2 goes to TURN
        req = 4'b0110;
        tick();
        tick();
        tick();
        check("t3_gnt", 32'(gnt), 4'b0010);
        for (int i = 0; i < 7; i++) tick();
        check("t3_gnt_hold8", 32'(gnt), 4'b0010);
        check("t3_timeout_early", 32'(timeout), 0);
        tick();
        check("t3_gnt_forced", 32'(gnt), 0);
        check("t3_oe_forced", 32'(uio_oe), 0);
        check("t3_timeout_pulse", 32'(timeout), 1);
`ifdef ARB_STATS_EN
        check("t3_timeout_cnt", 32'(timeout_cnt), 1);
`endif
        tick();
        check("t3_timeout_end", 32'(timeout), 0);
        check("t3_busy_turn2", 32'(busy), 1);

        // requester 2 drops in its second TURN cycle: abort, pointer stays on 2
        tick();
        req = '0;
        tick();
        check("t4_busy_abort", 32'(busy), 0);
        check("t4_gnt_abort", 32'(gnt), 0);
        req = 4'b1100;
        tick();
        tick();
        check("t4_gnt_none", 32'(gnt), 0);
        tick();
        check("t4_gnt_re", 32'(gnt), 4'b0100);
        rel = 4'b1000;
        tick();
        rel = '0;
        check("t4_gnt_nonowner_rel", 32'(gnt), 4'b0100);
        check("t4_oe", 32'(uio_oe), 8'hC3);
        check("t4_out", 32'(uio_out), 8'hC2);

        // ena low mid-grant, then re-grant of the same owner after 1+TURN_CYC cycles
        ena = 1'b0;
        tick();
        check("t5_gnt_ena", 32'(gnt), 0);
        check("t5_oe_ena", 32'(uio_oe), 0);
        check("t5_busy_ena", 32'(busy), 0);
        ena = 1'b1;
        tick();
        tick();
        check("t5_gnt_wait", 32'(gnt), 0);
        tick();
        check("t5_gnt_re", 32'(gnt), 4'b0100);

        // reset mid-grant clears outputs and pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_gnt", 32'(gnt), 0);
        check("t6_oe", 32'(uio_oe), 0);
        check("t6_out", 32'(uio_out), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_timeout", 32'(timeout), 0);
`ifdef ARB_STATS_EN
        check("t6_grant_cnt", 32'(grant_cnt), 0);
        check("t6_timeout_cnt", 32'(timeout_cnt), 0);
`endif
        req = 4'b1010;
        tick();
        tick();
        tick();
        check("t6_gnt_ptr0", 32'(gnt), 4'b0010);
        tick();
        check("t6_oe", 32'(uio_oe), 8'h0F);
        check("t6_out", 32'(uio_out), 8'hB1);
`ifdef ARB_STATS_EN
        check("t6_grant_cnt1", 32'(grant_cnt), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
